mac_seq_ctrl: RTL and testbench

Execute-stage sequencer for the MADD/MADDU/MSUB/MSUBU multiply-accumulate instructions in the OpenMIPS pipeline. It latches operands and holds the pipeline with a stall request. It forms the 64-bit product, then adds it to or subtracts it from the forwarded HI/LO pair. The result is presented to the HI/LO write path as a single-cycle write strobe. It sits beside the EX-stage ALU and feeds stallreq to the pipeline ctrl block.

---
 rtl/mac_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// ============================================================================
// Module   : mac_seq_ctrl
// Brief    : EX-stage sequencer for MADD/MADDU/MSUB/MSUBU. Latches operand
//            magnitudes, forms the 2*DW product, accumulates it into the
//            forwarded HI/LO pair and issues a one-cycle HI/LO write strobe
//            while holding the pipeline through stallreq_o.
// Options  : MAC_ITER_MUL_EN - when defined, MUL is a DW-cycle shift-add
//            multiplier driven by an iteration counter; when undefined, MUL
//            is a single-cycle combinational multiply.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_ctrl #(
  parameter int DW         = 32,
  parameter int ITER_CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] opdata1_i,
  input  logic [DW-1:0] opdata2_i,
  input  logic [DW-1:0] hi_i,
  input  logic [DW-1:0] lo_i,
  input  logic          flush_i,
  output logic          stallreq_o,
  output logic          busy_o,
  output logic          whilo_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  // The iteration counter must count exactly DW partial products.
  if ((1 << ITER_CNT_W) != DW) begin : g_cfg_check
    $error("mac_seq_ctrl: 2**ITER_CNT_W must equal DW");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic            sub_r;      // 1: subtract product from HI/LO
  logic            sign_r;     // 1: product must be negated
  logic [DW-1:0]   mag_a;
  logic [DW-1:0]   mag_b;
  logic [2*DW-1:0] prod_r;

  // op_i[0]==0 selects the signed variants (MADD, MSUB).
  logic            op_signed;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;
  logic            new_sign;
  logic [2*DW-1:0] hilo_in;
  logic [2*DW-1:0] acc_sum;
  logic [2*DW-1:0] mul_res;

  assign op_signed = ~op_i[0];
  // 0x80..0 negates to itself; read as unsigned it is the correct magnitude.
  assign abs_a     = (op_signed && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
  assign abs_b     = (op_signed && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;
  assign new_sign  = op_signed & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);

  assign hilo_in   = {hi_i, lo_i};
  assign acc_sum   = sub_r ? (hilo_in - prod_r) : (hilo_in + prod_r);

`ifdef MAC_ITER_MUL_EN
  localparam logic [ITER_CNT_W-1:0] CNT_LAST = ITER_CNT_W'(DW - 1);

  logic [ITER_CNT_W-1:0] iter_cnt;
  logic [2*DW-1:0]       part_prod;
  logic [2*DW-1:0]       part_sum;

  // prod_r accumulates one shifted copy of mag_b per set bit of mag_a.
  assign part_prod = mag_a[iter_cnt] ? ({{DW{1'b0}}, mag_b} << iter_cnt) : '0;
  assign part_sum  = prod_r + part_prod;
  assign mul_res   = sign_r ? -part_sum : part_sum;
`else
  logic [2*DW-1:0] full_prod;

  assign full_prod = {{DW{1'b0}}, mag_a} * {{DW{1'b0}}, mag_b};
  assign mul_res   = sign_r ? -full_prod : full_prod;
`endif

  // Stall request: raised in the accepting IDLE cycle and through MUL/ACC.
  always_comb begin
    stallreq_o = 1'b0;
    if (rst && !flush_i) begin
      case (state)
        IDLE:    stallreq_o = start_i;
        MUL:     stallreq_o = 1'b1;
        ACC:     stallreq_o = 1'b1;
        default: stallreq_o = 1'b0;
      endcase
    end
  end

  // Sequencer FSM with registered busy/write-strobe/result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sub_r   <= 1'b0;
      sign_r  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      prod_r  <= '0;
      busy_o  <= 1'b0;
      whilo_o <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
`ifdef MAC_ITER_MUL_EN
      iter_cnt <= '0;
`endif
    end else if (flush_i) begin
      // Annul: results already in hi_o/lo_o are kept.
      state   <= IDLE;
      busy_o  <= 1'b0;
      whilo_o <= 1'b0;
`ifdef MAC_ITER_MUL_EN
      iter_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          whilo_o <= 1'b0;
          if (start_i) begin
            sub_r  <= op_i[1];
            sign_r <= new_sign;
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            prod_r <= '0;
            busy_o <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
`ifdef MAC_ITER_MUL_EN
          if (iter_cnt == CNT_LAST) begin
            prod_r   <= mul_res;
            iter_cnt <= '0;
            state    <= ACC;
          end else begin
            prod_r   <= part_sum;
            iter_cnt <= iter_cnt + ITER_CNT_W'(1);
          end
`else
          prod_r <= mul_res;
          state  <= ACC;
`endif
        end
        ACC: begin
          {hi_o, lo_o} <= acc_sum;
          whilo_o      <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          whilo_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          whilo_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// ============================================================================
// Module   : tb_mac_seq_ctrl
// Brief    : Self-checking bench for mac_seq_ctrl: directed scenarios with
//            literal results plus randomized traffic against a latency/
//            arithmetic reference model.
// Options  : MAC_ITER_MUL_EN - selects the iterative-multiplier latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_seq_ctrl;

  localparam int DW = 32;
`ifdef MAC_ITER_MUL_EN
  localparam int LAT = DW + 2;   // cycle index of the write strobe
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [DW-1:0] opdata1_i = '0;
  logic [DW-1:0] opdata2_i = '0;
  logic [DW-1:0] hi_i = '0;
  logic [DW-1:0] lo_i = '0;
  logic          flush_i = 1'b0;
  logic          stallreq_o;
  logic          busy_o;
  logic          whilo_o;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  mac_seq_ctrl #(.DW(DW), .ITER_CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .hi_i(hi_i), .lo_i(lo_i),
    .flush_i(flush_i), .stallreq_o(stallreq_o), .busy_o(busy_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: m_pos = cycles since the accepting cycle (0 = idle).
  int          m_pos  = 0;
  logic        m_sub  = 1'b0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_hold = '0;
  logic        saw_whilo, saw_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] model_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // One clock cycle: drive, compare at negedge, advance the model.
  task automatic cycle(input logic s, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] h, input logic [31:0] l, input logic f);
    logic e_stall, e_busy, e_whilo;
    start_i = s; op_i = o; opdata1_i = a; opdata2_i = b; hi_i = h; lo_i = l; flush_i = f;
    @(negedge clk);
    if (!rst) begin
      m_pos = 0; m_hold = '0;
      e_stall = 1'b0; e_busy = 1'b0; e_whilo = 1'b0;
    end else begin
      e_stall = f ? 1'b0 : ((m_pos == 0) ? s : (m_pos < LAT));
      e_busy  = (m_pos != 0);
      e_whilo = (m_pos == LAT);
    end
    chk("stallreq", 64'(stallreq_o), 64'(e_stall));
    chk("busy",     64'(busy_o),     64'(e_busy));
    chk("whilo",    64'(whilo_o),    64'(e_whilo));
    chk("hilo",     {hi_o, lo_o},    m_hold);
    saw_whilo = whilo_o;
    saw_busy  = busy_o;
    if (rst) begin
      if (f) m_pos = 0;
      else if (m_pos == 0) begin
        if (s) begin
          m_pos  = 1;
          m_sub  = o[1];
          m_prod = model_prod(o, a, b);
        end
      end else if (m_pos == LAT - 1) begin
        m_hold = m_sub ? ({h, l} - m_prod) : ({h, l} + m_prod);
        m_pos  = LAT;
      end else if (m_pos == LAT) m_pos = 0;
      else m_pos++;
    end
    @(posedge clk);
    #1;
  endtask

  // Directed operation with literal expected result and strobe cycle.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        input logic [31:0] eh, input logic [31:0] el);
    int idx = -1;
    cycle(1'b1, o, a, b, h, l, 1'b0);
    for (int i = 1; i <= LAT + 3 && idx < 0; i++) begin
      cycle(1'b0, 2'($urandom), $urandom, $urandom, h, l, 1'b0);
      if (saw_whilo) idx = i;
    end
    chk({name, "_strobe_cycle"}, 64'(idx), 64'(LAT));
    chk({name, "_hi"}, 64'(hi_o), 64'(eh));
    chk({name, "_lo"}, 64'(lo_o), 64'(el));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edges [5];
    edges = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
    if ($urandom_range(0, 5) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    // Reset state
    #12;
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    chk("reset_busy",  64'(busy_o),     64'd0);
    chk("reset_hilo",  {hi_o, lo_o},    64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

    run_op("maddu", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h5, 32'h2, 32'h3);
    run_op("madd",  2'b00, 32'hFFFF_FFFF, 32'h3, 32'h0, 32'hA, 32'h0, 32'h7);
    run_op("msub",  2'b10, 32'h2, 32'h3, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("madd_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 32'h0);
    run_op("msub_min", 2'b10, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 32'h0, 32'h8000_0000);
    run_op("msubu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF);

    // Flush in MUL, then a back-to-back op
    cycle(1'b1, 2'b00, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("flush_busy_after", 64'(saw_busy), 64'd0);
    chk("flush_hilo_kept", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFF);
    // Start and flush together in IDLE: not accepted
    cycle(1'b1, 2'b01, 32'h5, 32'h5, 32'h0, 32'h0, 1'b1);
    cycle(1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("start_flush_busy", 64'(saw_busy), 64'd0);
    run_op("b2b_maddu", 2'b01, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1);

    // Asynchronous reset during ACC
    cycle(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h5, 1'b0);
    for (int i = 1; i < LAT - 1; i++) cycle(1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h5, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst_stall", 64'(stallreq_o), 64'd0);
    chk("arst_busy",  64'(busy_o),     64'd0);
    chk("arst_whilo", 64'(whilo_o),    64'd0);
    chk("arst_hi",    64'(hi_o),       64'd0);
    chk("arst_lo",    64'(lo_o),       64'd0);
    m_pos = 0; m_hold = '0;
    cycle(1'b1, 2'b01, 32'h3, 32'h3, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 2'b01, 32'h3, 32'h3, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 2'b01, 32'h3, 32'h3, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 2'b01, 32'h3, 32'h3, 32'h0, 32'h0, 1'b0);
    chk("post_reset_idle", 64'(saw_busy), 64'd0);
    run_op("post_reset_op", 2'b01, 32'h3, 32'h3, 32'h0, 32'h1, 32'h0, 32'hA);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 2) == 0, 2'($urandom), pick_operand(), pick_operand(),
            pick_operand(), pick_operand(), $urandom_range(0, 24) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
